// File: rtl/gun_ctrl.sv
// rtl/gun_ctrl.sv - laser-gun controller: ammo, fire modes, regen, LED bar, BCD count
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   trigger          synchronised fire switch (level)
//   mode             00 auto, 01 burst, 10 single, 11 auto; sampled in IDLE only
//   shooting         emitter enable (registered from FSM state)
//   buzzer           active low, 0 while shooting
//   led              LED bar pattern
//   ammo, ammo_bcd   round count in binary and as {4'h0, hundreds, tens, ones}
//   empty            ammo == 0
//   overheat         overheat lockout active
//
// Optional macro GUN_OVERHEAT_EN adds the heat counter and the OVERHEAT state;
// without it overheat is tied to 0.

module gun_ctrl #(
   parameter int MAG_SIZE    = 100,
   parameter int FIRE_TICKS  = 4194304,
   parameter int REGEN_TICKS = 4194304,
   parameter int LED_TICKS   = 8388608,
   parameter int LED_W       = 16,
   parameter int BURST_LEN   = 3,
   parameter int HEAT_MAX    = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trigger,
   input  logic [1:0]       mode,
   output logic             shooting,
   output logic             buzzer,
   output logic [LED_W-1:0] led,
   output logic [9:0]       ammo,
   output logic [15:0]      ammo_bcd,
   output logic             empty,
   output logic             overheat
);

   localparam int TW = $clog2(FIRE_TICKS + 1);
   localparam int RW = $clog2(REGEN_TICKS + 1);
   localparam int LW = $clog2(LED_TICKS + 1);
   localparam int BW = $clog2(BURST_LEN + 1);

   localparam logic [TW-1:0]    TICK_LAST  = TW'(FIRE_TICKS - 1);
   localparam logic [RW-1:0]    REGEN_LAST = RW'(REGEN_TICKS - 1);
   localparam logic [LW-1:0]    LED_LAST   = LW'(LED_TICKS - 1);
   localparam logic [BW-1:0]    BURST_INIT = BW'(BURST_LEN);
   localparam logic [9:0]       MAG        = 10'(MAG_SIZE);
   localparam logic [LED_W-1:0] CHASE_INIT = LED_W'(3'b111);
   localparam logic [LED_W-1:0] LED_ONES   = '1;

   // Reset value of the BCD counter; constant arithmetic, folded at elaboration.
   localparam logic [3:0] RST_H = 4'((MAG_SIZE / 100) % 10);
   localparam logic [3:0] RST_T = 4'((MAG_SIZE / 10) % 10);
   localparam logic [3:0] RST_O = 4'(MAG_SIZE % 10);

   typedef enum logic [2:0] {
      S_IDLE, S_AUTO, S_BURST, S_SINGLE, S_HOLD, S_OVERHEAT
   } state_t;

   typedef enum logic [1:0] {LED_NONE, LED_CHASE, LED_ALT} led_src_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [RW-1:0]   regen_q;
   logic [LW-1:0]   led_cnt_q;
   led_src_t        led_src_q;
   logic [3:0]      bcd_h, bcd_t, bcd_o;
   logic [3:0]      bcd_h_d, bcd_t_d, bcd_o_d;
   logic [9:0]      ammo_d;
   logic            firing, dec, inc, regen_active, heat_lock;

`ifdef GUN_OVERHEAT_EN
   localparam int HW = $clog2(HEAT_MAX + 1);
   localparam logic [HW-1:0] HEAT_LAST = HW'(HEAT_MAX);

   function automatic logic [LED_W-1:0] alt_pattern();
      logic [LED_W-1:0] p;
      for (int i = 0; i < LED_W; i++) p[i] = i[0];
      return p;
   endfunction
   localparam logic [LED_W-1:0] LED_ALT_PAT = alt_pattern();

   logic [HW-1:0] heat_q;
   logic [RW-1:0] cool_q;
`endif

   assign firing       = (state_q == S_AUTO) || (state_q == S_BURST) || (state_q == S_SINGLE);
   assign regen_active = (state_q == S_IDLE) && !trigger && (ammo < MAG);
   assign inc          = regen_active && (regen_q == REGEN_LAST);

`ifdef GUN_OVERHEAT_EN
   assign heat_lock = (heat_q == HEAT_LAST);
`else
   assign heat_lock = 1'b0;
`endif

   // Next-state logic. A round is charged only on the terminal tick of a firing
   // state; leaving early (trigger release in AUTO, overheat) discards the tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      burst_d = burst_q;
      dec     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (trigger) begin
               if (ammo != 10'd0) begin
                  burst_d = BURST_INIT;
                  case (mode)
                     2'b01:   state_d = S_BURST;
                     2'b10:   state_d = S_SINGLE;
                     default: state_d = S_AUTO;
                  endcase
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_AUTO, S_BURST, S_SINGLE: begin
            if (heat_lock) begin
               state_d = S_OVERHEAT;
               tick_d  = '0;
            end else if ((state_q == S_AUTO) && !trigger) begin
               state_d = S_IDLE;
               tick_d  = '0;
            end else if (tick_q == TICK_LAST) begin
               dec    = 1'b1;
               tick_d = '0;
               if (state_q == S_BURST) burst_d = burst_q - BW'(1);
               if ((ammo == 10'd1) || (state_q == S_SINGLE) ||
                   ((state_q == S_BURST) && (burst_q == BW'(1))))
                  state_d = S_HOLD;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         S_HOLD: begin
            if (!trigger) state_d = S_IDLE;
         end
         S_OVERHEAT: begin
`ifdef GUN_OVERHEAT_EN
            if (heat_q == '0) state_d = S_HOLD;
`else
            state_d = S_HOLD;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ammo in binary and BCD; decrement and increment are mutually exclusive
   // because one needs a firing state and the other needs IDLE.
   always_comb begin
      ammo_d  = ammo;
      bcd_h_d = bcd_h;
      bcd_t_d = bcd_t;
      bcd_o_d = bcd_o;
      if (dec) begin
         ammo_d = ammo - 10'd1;
         if (bcd_o != 4'd0) begin
            bcd_o_d = bcd_o - 4'd1;
         end else begin
            bcd_o_d = 4'd9;
            if (bcd_t != 4'd0) begin
               bcd_t_d = bcd_t - 4'd1;
            end else begin
               bcd_t_d = 4'd9;
               bcd_h_d = bcd_h - 4'd1;
            end
         end
      end else if (inc) begin
         ammo_d = ammo + 10'd1;
         if (bcd_o != 4'd9) begin
            bcd_o_d = bcd_o + 4'd1;
         end else begin
            bcd_o_d = 4'd0;
            if (bcd_t != 4'd9) begin
               bcd_t_d = bcd_t + 4'd1;
            end else begin
               bcd_t_d = 4'd0;
               bcd_h_d = bcd_h + 4'd1;
            end
         end
      end
   end

   assign ammo_bcd = {4'h0, bcd_h, bcd_t, bcd_o};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         burst_q  <= '0;
         regen_q  <= '0;
         ammo     <= MAG;
         bcd_h    <= RST_H;
         bcd_t    <= RST_T;
         bcd_o    <= RST_O;
         empty    <= (MAG_SIZE == 0);
         shooting <= 1'b0;
         buzzer   <= 1'b1;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         burst_q  <= burst_d;
         regen_q  <= (regen_active && !inc) ? regen_q + RW'(1) : '0;
         ammo     <= ammo_d;
         bcd_h    <= bcd_h_d;
         bcd_t    <= bcd_t_d;
         bcd_o    <= bcd_o_d;
         empty    <= (ammo_d == 10'd0);
         shooting <= firing;
         buzzer   <= !firing;
      end
   end

   // LED bar. led_src_q remembers which animation is loaded so that entering a
   // pattern from any other display restarts it from its initial value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led       <= '0;
         led_cnt_q <= '0;
         led_src_q <= LED_NONE;
      end else if (firing) begin
         led       <= LED_ONES;
         led_cnt_q <= '0;
         led_src_q <= LED_NONE;
`ifdef GUN_OVERHEAT_EN
      end else if (state_q == S_OVERHEAT) begin
         if (led_src_q != LED_ALT) begin
            led       <= LED_ALT_PAT;
            led_cnt_q <= '0;
            led_src_q <= LED_ALT;
         end else if (led_cnt_q == LED_LAST) begin
            led       <= ~led;
            led_cnt_q <= '0;
         end else begin
            led_cnt_q <= led_cnt_q + LW'(1);
         end
`endif
      end else if (trigger && (ammo == 10'd0)) begin
         led       <= '0;
         led_cnt_q <= '0;
         led_src_q <= LED_NONE;
      end else if (ammo < MAG) begin
         if (led_src_q != LED_CHASE) begin
            led       <= CHASE_INIT;
            led_cnt_q <= '0;
            led_src_q <= LED_CHASE;
         end else if (led_cnt_q == LED_LAST) begin
            led       <= (led == '0) ? CHASE_INIT : (led << 1);
            led_cnt_q <= '0;
         end else begin
            led_cnt_q <= led_cnt_q + LW'(1);
         end
      end else begin
         led       <= '0;
         led_cnt_q <= '0;
         led_src_q <= LED_NONE;
      end
   end

`ifdef GUN_OVERHEAT_EN
   // Heat rises per charged round and cools one step per REGEN_TICKS while
   // not firing; cool_q only runs while there is heat to shed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         heat_q   <= '0;
         cool_q   <= '0;
         overheat <= 1'b0;
      end else begin
         overheat <= (state_q == S_OVERHEAT);
         if (dec) begin
            if (heat_q != HEAT_LAST) heat_q <= heat_q + HW'(1);
            cool_q <= '0;
         end else if (!firing && (heat_q != '0)) begin
            if (cool_q == REGEN_LAST) begin
               heat_q <= heat_q - HW'(1);
               cool_q <= '0;
            end else begin
               cool_q <= cool_q + RW'(1);
            end
         end else begin
            cool_q <= '0;
         end
      end
   end
`else
   assign overheat = 1'b0;
`endif

endmodule

// File: tb/tb_gun_ctrl.sv
// tb/tb_gun_ctrl.sv - directed self-checking bench for gun_ctrl

module tb_gun_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic [1:0]  mode;
   logic        shooting, buzzer, empty, overheat;
   logic [15:0] led;
   logic [9:0]  ammo;
   logic [15:0] ammo_bcd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gun_ctrl #(
      .MAG_SIZE(10), .FIRE_TICKS(4), .REGEN_TICKS(8), .LED_TICKS(2),
      .LED_W(16), .BURST_LEN(3), .HEAT_MAX(2)
   ) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .mode(mode),
      .shooting(shooting), .buzzer(buzzer), .led(led), .ammo(ammo),
      .ammo_bcd(ammo_bcd), .empty(empty), .overheat(overheat)
   );

   task automatic apply_reset();
      rst = 1'b1; trigger = 1'b0; mode = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (ammo !== 10'd10) begin n_bad++; $display("FAIL reset_ammo: got %0d want 10", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0010) begin n_bad++; $display("FAIL reset_bcd: got %h want 0010", ammo_bcd); end
      n_cmp++; if (buzzer !== 1'b1) begin n_bad++; $display("FAIL reset_buzzer: got %b want 1", buzzer); end
      n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL reset_led: got %h want 0000", led); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL reset_shooting: got %b want 0", shooting); end
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL reset_empty: got %b want 0", empty); end
      n_cmp++; if (overheat !== 1'b0) begin n_bad++; $display("FAIL reset_overheat: got %b want 0", overheat); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      trigger = 1'b1;
      cycles(10);
      n_cmp++; if (ammo !== 10'd8) begin n_bad++; $display("FAIL async_pre_ammo: got %0d want 8", ammo); end
      n_cmp++; if (shooting !== 1'b1) begin n_bad++; $display("FAIL async_pre_shooting: got %b want 1", shooting); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (ammo !== 10'd10) begin n_bad++; $display("FAIL async_ammo: got %0d want 10", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0010) begin n_bad++; $display("FAIL async_bcd: got %h want 0010", ammo_bcd); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL async_shooting: got %b want 0", shooting); end
      n_cmp++; if (buzzer !== 1'b1) begin n_bad++; $display("FAIL async_buzzer: got %b want 1", buzzer); end
      n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL async_led: got %h want 0000", led); end
      trigger = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_auto();
      apply_reset();
      mode = 2'b00; trigger = 1'b1;
      cycles(1);
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL auto_latency: got %b want 0", shooting); end
      cycles(1);
      n_cmp++; if (shooting !== 1'b1) begin n_bad++; $display("FAIL auto_shooting: got %b want 1", shooting); end
      n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL auto_buzzer: got %b want 0", buzzer); end
      n_cmp++; if (led !== 16'hFFFF) begin n_bad++; $display("FAIL auto_led: got %h want ffff", led); end
      cycles(2);
      n_cmp++; if (ammo !== 10'd10) begin n_bad++; $display("FAIL auto_no_early_dec: got %0d want 10", ammo); end
      cycles(1);
      n_cmp++; if (ammo !== 10'd9) begin n_bad++; $display("FAIL auto_first_round: got %0d want 9", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0009) begin n_bad++; $display("FAIL auto_bcd_borrow: got %h want 0009", ammo_bcd); end
      cycles(12);
      n_cmp++; if (ammo !== 10'd6) begin n_bad++; $display("FAIL auto_fourth_round: got %0d want 6", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0006) begin n_bad++; $display("FAIL auto_bcd6: got %h want 0006", ammo_bcd); end
      cycles(3);
      trigger = 1'b0;
      cycles(3);
      n_cmp++; if (ammo !== 10'd6) begin n_bad++; $display("FAIL auto_partial_tick: got %0d want 6", ammo); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL auto_release: got %b want 0", shooting); end
   endtask

   task automatic test_burst();
      int shots;
      apply_reset();
      mode = 2'b01; trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      shots = 0;
      repeat (16) begin
         if (shooting === 1'b1) shots++;
         @(negedge clk);
      end
      n_cmp++; if (shots !== 12) begin n_bad++; $display("FAIL burst_cycles: got %0d want 12", shots); end
      n_cmp++; if (ammo !== 10'd7) begin n_bad++; $display("FAIL burst_ammo: got %0d want 7", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0007) begin n_bad++; $display("FAIL burst_bcd: got %h want 0007", ammo_bcd); end

      apply_reset();
      mode = 2'b01; trigger = 1'b1;
      shots = 0;
      repeat (30) begin
         if (shooting === 1'b1) shots++;
         @(negedge clk);
      end
      n_cmp++; if (shots !== 12) begin n_bad++; $display("FAIL burst_held_cycles: got %0d want 12", shots); end
      n_cmp++; if (ammo !== 10'd7) begin n_bad++; $display("FAIL burst_held_ammo: got %0d want 7", ammo); end
      trigger = 1'b0;
      cycles(2);
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL burst_release: got %b want 0", shooting); end
      n_cmp++; if (ammo !== 10'd7) begin n_bad++; $display("FAIL burst_release_ammo: got %0d want 7", ammo); end
   endtask

   task automatic test_drain_regen();
      apply_reset();
      mode = 2'b00; trigger = 1'b1;
      cycles(45);
      n_cmp++; if (ammo !== 10'd0) begin n_bad++; $display("FAIL drain_ammo: got %0d want 0", ammo); end
      n_cmp++; if (ammo_bcd !== 16'h0000) begin n_bad++; $display("FAIL drain_bcd: got %h want 0000", ammo_bcd); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL drain_shooting: got %b want 0", shooting); end
      n_cmp++; if (buzzer !== 1'b1) begin n_bad++; $display("FAIL drain_buzzer: got %b want 1", buzzer); end
      n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL drain_led: got %h want 0000", led); end
      cycles(5);
      trigger = 1'b0;
      cycles(1);
      n_cmp++; if (led !== 16'h0007) begin n_bad++; $display("FAIL chase_entry: got %h want 0007", led); end
      cycles(2);
      n_cmp++; if (led !== 16'h000E) begin n_bad++; $display("FAIL chase_shift1: got %h want 000e", led); end
      cycles(2);
      n_cmp++; if (led !== 16'h001C) begin n_bad++; $display("FAIL chase_shift2: got %h want 001c", led); end
      cycles(3);
      n_cmp++; if (ammo !== 10'd0) begin n_bad++; $display("FAIL regen_early: got %0d want 0", ammo); end
      cycles(1);
      n_cmp++; if (ammo !== 10'd1) begin n_bad++; $display("FAIL regen_first: got %0d want 1", ammo); end
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL regen_empty: got %b want 0", empty); end
      cycles(64);
      n_cmp++; if (ammo_bcd !== 16'h0009) begin n_bad++; $display("FAIL regen_bcd9: got %h want 0009", ammo_bcd); end
      cycles(8);
      n_cmp++; if (ammo_bcd !== 16'h0010) begin n_bad++; $display("FAIL regen_bcd_carry: got %h want 0010", ammo_bcd); end
      cycles(2);
      n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL full_led: got %h want 0000", led); end
      cycles(17);
      n_cmp++; if (ammo !== 10'd10) begin n_bad++; $display("FAIL regen_saturate: got %0d want 10", ammo); end
   endtask

   task automatic test_single();
      int shots;
      apply_reset();
      mode = 2'b00; trigger = 1'b1;
      cycles(37);
      n_cmp++; if (ammo !== 10'd1) begin n_bad++; $display("FAIL single_setup: got %0d want 1", ammo); end
      trigger = 1'b0;
      cycles(1);
      mode = 2'b10; trigger = 1'b1;
      cycles(1);
      trigger = 1'b0; mode = 2'b00;
      shots = 0;
      repeat (10) begin
         if (shooting === 1'b1) shots++;
         @(negedge clk);
      end
      n_cmp++; if (shots !== 4) begin n_bad++; $display("FAIL single_cycles: got %0d want 4", shots); end
      n_cmp++; if (ammo !== 10'd0) begin n_bad++; $display("FAIL single_ammo: got %0d want 0", ammo); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty: got %b want 1", empty); end
   endtask

`ifdef GUN_OVERHEAT_EN
   task automatic test_overheat();
      apply_reset();
      mode = 2'b00; trigger = 1'b1;
      cycles(11);
      n_cmp++; if (overheat !== 1'b1) begin n_bad++; $display("FAIL heat_on: got %b want 1", overheat); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL heat_shooting: got %b want 0", shooting); end
      n_cmp++; if (ammo !== 10'd8) begin n_bad++; $display("FAIL heat_ammo: got %0d want 8", ammo); end
      n_cmp++; if (led !== 16'hAAAA) begin n_bad++; $display("FAIL heat_led: got %h want aaaa", led); end
      cycles(2);
      n_cmp++; if (led !== 16'h5555) begin n_bad++; $display("FAIL heat_led_toggle: got %h want 5555", led); end
      cycles(13);
      n_cmp++; if (overheat !== 1'b1) begin n_bad++; $display("FAIL heat_still_on: got %b want 1", overheat); end
      cycles(3);
      n_cmp++; if (overheat !== 1'b0) begin n_bad++; $display("FAIL heat_off: got %b want 0", overheat); end
      n_cmp++; if (shooting !== 1'b0) begin n_bad++; $display("FAIL heat_hold: got %b want 0", shooting); end
      trigger = 1'b0;
      cycles(2);
   endtask
`endif

   initial begin
      test_reset();
      test_async_reset();
      test_auto();
      test_burst();
      test_drain_regen();
      test_single();
`ifdef GUN_OVERHEAT_EN
      test_overheat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
